iack_initiator: RTL and testbench

- Bus-master-side interrupt unit for the soft 68k-compatible core. Runs the CPU end of the interrupt protocol.
- Samples and qualifies the encoded ipl_n lines against the core's SR mask and raises a request to the core at instruction boundaries.
- On command, runs a 68000-style interrupt-acknowledge (IACK) bus cycle and returns a vector to the core:
  - vectored: DTACK plus data byte;
  - autovector: VPA;
  - spurious: BERR or timeout.
- Sits between the core sequencer and the system bus, opposite the interrupt controller.

---
 rtl/m68k_bus_pkg.sv | 23 ++
 rtl/iack_initiator_ipl_sync.sv | 26 ++
 rtl/iack_initiator.sv | 170 +++++++++++++++++
 tb/tb_iack_initiator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared 68k bus definitions: function codes, IACK FSM states, default vectors.
package m68k_bus_pkg;

  localparam logic [2:0] FC_NONE = 3'b000;
  localparam logic [2:0] FC_IACK = 3'b111;

  localparam logic [7:0] DEF_SPURIOUS_VEC = 8'h18;
  localparam logic [7:0] DEF_AUTOVEC_BASE = 8'h18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT,
    ST_RELEASE,
    ST_DONE
  } iack_state_e;

  // Autovector number: base plus level, wrapping in 8 bits.
  function automatic logic [7:0] autovec(input logic [7:0] base, input logic [2:0] lvl);
    return base + {5'b00000, lvl};
  endfunction

endpackage

// File: rtl/iack_initiator_ipl_sync.sv
// Synchronises the asynchronous ipl_n lines and filters single-sample glitches.
// A level is accepted only when both synchroniser stages agree, giving a
// 3-clk latency from an ipl_n change to stable_lvl.
module ipl_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ipl_n,
  output logic [2:0] stable_lvl
);

  logic [2:0] s1, s2;

  // Two-flop synchroniser (idle = all high = level 0) plus equality filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 3'b111;
      s2         <= 3'b111;
      stable_lvl <= 3'd0;
    end else begin
      s1 <= ipl_n;
      s2 <= s1;
      if (s1 == s2) stable_lvl <= ~s2;
    end
  end

endmodule

// File: rtl/iack_initiator.sv
// CPU-side interrupt unit: qualifies ipl against the SR mask, raises irq_req,
// and runs the 68000 interrupt-acknowledge bus cycle to fetch a vector.
module iack_initiator
  import m68k_bus_pkg::*;
#(
  parameter int         TIMEOUT_CYC  = 64,
  parameter logic [7:0] SPURIOUS_VEC = DEF_SPURIOUS_VEC,
  parameter logic [7:0] AUTOVEC_BASE = DEF_AUTOVEC_BASE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ipl_n,
  input  logic [2:0] sr_mask,
  output logic       irq_req,
  output logic [2:0] irq_level,
  input  logic       iack_start,
  output logic       vec_valid,
  output logic [7:0] vector,
  output logic [2:0] vec_level,
  output logic       spurious,
  output logic [2:0] fc,
  output logic [2:0] addr,
  output logic       as_n,
  output logic       intr_cycle_n,
  input  logic       dtack_n,
  input  logic       vpa_n,
  input  logic       berr_n,
  input  logic [7:0] data_in
);

  localparam int CW = (TIMEOUT_CYC < 4) ? 2 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  iack_state_e   state, state_nxt;
  logic [2:0]    stable_lvl, stable_d;
  logic          nmi_pend, nmi_edge, nmi_pend_nxt, lvl_req, busy;
  logic [2:0]    cur_lvl, cur_lvl_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    vec_r, vec_nxt;
  logic          spur_r, spur_nxt;
  logic [2:0]    fc_nxt, addr_nxt;
  logic          as_nxt, ic_nxt;

  ipl_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ipl_n      (ipl_n),
    .stable_lvl (stable_lvl)
  );

  // Level 7 is edge-triggered; a new edge wins over the clear at DONE.
  always_comb begin
    nmi_edge     = (stable_lvl == 3'd7) && (stable_d != 3'd7);
    nmi_pend_nxt = nmi_pend;
    if (state == ST_DONE && cur_lvl == 3'd7) nmi_pend_nxt = 1'b0;
    if (nmi_edge) nmi_pend_nxt = 1'b1;
    lvl_req = (stable_lvl != 3'd7) && (stable_lvl > sr_mask);
    busy    = (state != ST_IDLE) || (iack_start && irq_req);
  end

  // Qualification registers: request is held off while an IACK is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d  <= 3'd0;
      nmi_pend  <= 1'b0;
      irq_req   <= 1'b0;
      irq_level <= 3'd0;
    end else begin
      stable_d  <= stable_lvl;
      nmi_pend  <= nmi_pend_nxt;
      irq_req   <= !busy && (nmi_pend_nxt || lvl_req);
      irq_level <= nmi_pend_nxt ? 3'd7 : stable_lvl;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next bus-output logic; termination priority berr > dtack > vpa.
  always_comb begin
    state_nxt   = state;
    cur_lvl_nxt = cur_lvl;
    cnt_nxt     = cnt;
    vec_nxt     = vec_r;
    spur_nxt    = spur_r;
    fc_nxt      = fc;
    addr_nxt    = addr;
    as_nxt      = as_n;
    ic_nxt      = intr_cycle_n;
    case (state)
      ST_IDLE: begin
        if (iack_start && irq_req) begin
          state_nxt   = ST_ASSERT;
          cur_lvl_nxt = irq_level;
          fc_nxt      = FC_IACK;
          addr_nxt    = irq_level;
          ic_nxt      = 1'b0;
        end
      end
      ST_ASSERT: begin
        as_nxt    = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!berr_n || (dtack_n && vpa_n && cnt == CNT_LAST)) begin
          vec_nxt  = SPURIOUS_VEC;
          spur_nxt = 1'b1;
        end else if (!dtack_n) begin
          vec_nxt  = data_in;
          spur_nxt = 1'b0;
        end else if (!vpa_n) begin
          vec_nxt  = autovec(AUTOVEC_BASE, cur_lvl);
          spur_nxt = 1'b0;
        end
        if (!berr_n || !dtack_n || !vpa_n || cnt == CNT_LAST) begin
          state_nxt = ST_RELEASE;
          as_nxt    = 1'b1;
          ic_nxt    = 1'b1;
          fc_nxt    = FC_NONE;
          addr_nxt  = 3'd0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (dtack_n && vpa_n && berr_n) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs, cycle datapath, and vector publication on leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_lvl      <= 3'd0;
      cnt          <= '0;
      vec_r        <= 8'd0;
      spur_r       <= 1'b0;
      fc           <= FC_NONE;
      addr         <= 3'd0;
      as_n         <= 1'b1;
      intr_cycle_n <= 1'b1;
      vec_valid    <= 1'b0;
      vector       <= 8'd0;
      vec_level    <= 3'd0;
      spurious     <= 1'b0;
    end else begin
      cur_lvl      <= cur_lvl_nxt;
      cnt          <= cnt_nxt;
      vec_r        <= vec_nxt;
      spur_r       <= spur_nxt;
      fc           <= fc_nxt;
      addr         <= addr_nxt;
      as_n         <= as_nxt;
      intr_cycle_n <= ic_nxt;
      vec_valid    <= (state == ST_DONE);
      if (state == ST_DONE) begin
        vector    <= vec_r;
        vec_level <= cur_lvl;
        spurious  <= spur_r;
      end
    end
  end

endmodule

// File: tb/tb_iack_initiator.sv
// Directed bench for iack_initiator: qualification, IACK flavours, timeout, reset.
module tb_iack_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ipl_n;
  logic [2:0] sr_mask;
  logic       irq_req;
  logic [2:0] irq_level;
  logic       iack_start;
  logic       vec_valid;
  logic [7:0] vector;
  logic [2:0] vec_level;
  logic       spurious;
  logic [2:0] fc;
  logic [2:0] addr;
  logic       as_n;
  logic       intr_cycle_n;
  logic       dtack_n = 1'b1;
  logic       vpa_n   = 1'b1;
  logic       berr_n  = 1'b1;
  logic [7:0] data_in;

  int n_chk  = 0;
  int n_fail = 0;
  int resp_mode = 0;  // 0 none, 1 vpa, 2 dtack, 3 berr

  iack_initiator dut (
    .clk(clk), .rst_n(rst_n), .ipl_n(ipl_n), .sr_mask(sr_mask),
    .irq_req(irq_req), .irq_level(irq_level), .iack_start(iack_start),
    .vec_valid(vec_valid), .vector(vector), .vec_level(vec_level),
    .spurious(spurious), .fc(fc), .addr(addr), .as_n(as_n),
    .intr_cycle_n(intr_cycle_n), .dtack_n(dtack_n), .vpa_n(vpa_n),
    .berr_n(berr_n), .data_in(data_in)
  );

  always #5 clk = ~clk;

  // Responder: answers while AS is low, releases once AS goes high.
  always @(negedge clk) begin
    if (as_n === 1'b0) begin
      vpa_n   = !(resp_mode == 1);
      dtack_n = !(resp_mode == 2);
      berr_n  = !(resp_mode == 3);
    end else begin
      vpa_n   = 1'b1;
      dtack_n = 1'b1;
      berr_n  = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one IACK. lat counts posedges from the one sampling iack_start
  // (counted as 1) to the one after which vec_valid is seen high.
  task automatic do_iack(input int mode, output int lat, output int aslow,
                         output logic [2:0] fc0, output logic [2:0] addr0,
                         output logic ic0, output logic req0, output logic vv_after);
    logic seen;
    resp_mode  = mode;
    iack_start = 1'b1;
    tick();
    iack_start = 1'b0;
    fc0 = fc; addr0 = addr; ic0 = intr_cycle_n; req0 = irq_req;
    lat = 1; aslow = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      lat++;
      if (as_n === 1'b0) aslow++;
      if (vec_valid === 1'b1) seen = 1'b1;
    end
    tick();
    vv_after = vec_valid;
    resp_mode = 0;
  endtask

  int lat, aslow;
  logic [2:0] fc0, addr0;
  logic ic0, req0, vva, saw;

  initial begin
    rst_n = 1'b0; ipl_n = 3'b111; sr_mask = 3'd7; iack_start = 1'b0; data_in = 8'h00;
    ticks(2);
    chk("rst_irq_req", irq_req, 0);
    chk("rst_as_n", as_n, 1);
    chk("rst_intr_n", intr_cycle_n, 1);
    chk("rst_fc", fc, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vector", vector, 0);
    rst_n = 1'b1;
    tick();

    // Single-clock glitch to level 1 with mask 0 must never request.
    sr_mask = 3'd0; ipl_n = 3'b110;
    tick();
    ipl_n = 3'b111; saw = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (irq_req) saw = 1'b1; end
    chk("glitch_no_req", saw, 0);

    // Level 2, mask 1: exact latency, then autovector IACK.
    sr_mask = 3'd1; ipl_n = 3'b101;
    ticks(3);
    chk("l2_req_early", irq_req, 0);
    tick();
    chk("l2_req", irq_req, 1);
    chk("l2_level", irq_level, 2);
    do_iack(1, lat, aslow, fc0, addr0, ic0, req0, vva);
    chk("l2_fc", fc0, 3'b111);
    chk("l2_addr", addr0, 2);
    chk("l2_intr_n", ic0, 0);
    chk("l2_req_masked", req0, 0);
    chk("l2_vector", vector, 8'h1A);
    chk("l2_spurious", spurious, 0);
    chk("l2_vec_level", vec_level, 2);
    chk("l2_latency", lat, 5);
    chk("l2_pulse_1clk", vva, 0);
    chk("l2_fc_idle", fc, 0);

    // Level 5, mask 4: vectored via DTACK.
    sr_mask = 3'd4; ipl_n = 3'b010; data_in = 8'h51;
    ticks(5);
    chk("l5_req", irq_req, 1);
    chk("l5_level", irq_level, 5);
    do_iack(2, lat, aslow, fc0, addr0, ic0, req0, vva);
    chk("l5_vector", vector, 8'h51);
    chk("l5_vec_level", vec_level, 5);
    chk("l5_latency", lat, 5);
    chk("l5_spurious", spurious, 0);

    // NMI: edge-triggered, ignores mask 7, no re-request while held.
    sr_mask = 3'd7; ipl_n = 3'b000;
    ticks(5);
    chk("nmi_req", irq_req, 1);
    chk("nmi_level", irq_level, 7);
    do_iack(1, lat, aslow, fc0, addr0, ic0, req0, vva);
    chk("nmi_addr", addr0, 7);
    chk("nmi_vector", vector, 8'h1F);
    chk("nmi_vec_level", vec_level, 7);
    ticks(4);
    chk("nmi_held_no_req", irq_req, 0);
    ipl_n = 3'b111;
    ticks(5);
    ipl_n = 3'b000;
    ticks(5);
    chk("nmi_reedge_req", irq_req, 1);
    do_iack(1, lat, aslow, fc0, addr0, ic0, req0, vva);
    chk("nmi2_vector", vector, 8'h1F);

    // Level 3, mask 2: BERR, then no responder (timeout).
    sr_mask = 3'd2; ipl_n = 3'b100;
    ticks(5);
    chk("l3_req", irq_req, 1);
    chk("l3_level", irq_level, 3);
    do_iack(3, lat, aslow, fc0, addr0, ic0, req0, vva);
    chk("berr_vector", vector, 8'h18);
    chk("berr_spurious", spurious, 1);
    chk("berr_latency", lat, 5);
    ticks(2);
    do_iack(0, lat, aslow, fc0, addr0, ic0, req0, vva);
    chk("tmo_as_low", aslow, 64);
    chk("tmo_latency", lat, 68);
    chk("tmo_vector", vector, 8'h18);
    chk("tmo_spurious", spurious, 1);
    chk("tmo_vec_level", vec_level, 3);

    // Mask comparison is strict: level 4 vs mask 4 vs mask 3.
    sr_mask = 3'd4; ipl_n = 3'b011;
    ticks(5);
    chk("l4_m4_no_req", irq_req, 0);
    chk("l4_m4_level", irq_level, 4);
    sr_mask = 3'd3;
    tick();
    chk("l4_m3_req", irq_req, 1);

    // Reset while waiting for a response.
    resp_mode = 0;
    iack_start = 1'b1;
    tick();
    iack_start = 1'b0;
    ticks(2);
    chk("mid_as_low", as_n, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_as_n", as_n, 1);
    chk("rst_async_intr_n", intr_cycle_n, 1);
    chk("rst_async_fc", fc, 0);
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    ticks(3);
    chk("post_rst_req_early", irq_req, 0);
    tick();
    chk("post_rst_req", irq_req, 1);
    for (int i = 0; i < 6; i++) begin tick(); if (vec_valid) saw = 1'b1; end
    chk("post_rst_no_vv", saw, 0);
    chk("post_rst_vector", vector, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
